mul_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential 8x8 `mul` unit between N_REQ requesters, for example the cube-root and square-root engines.
- It sits between the requesters and a single `mul` instance.
- Per granted request it:
  - captures the operands;
  - pulses the multiplier's reset, then its start;
  - waits until the multiplier is not busy;
  - returns the 16-bit product with a one-cycle done pulse to the winning requester.

---
 rtl/mul_share_arb_pkg.sv | 17 +
 rtl/mul_share_arb_rr_pick.sv | 34 +++
 rtl/mul_share_arb.sv | 117 +++++++++++
 tb/tb_mul_share_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// FSM state encoding plus operand/result widths.
package mul_share_pkg;

  localparam int ST_W  = 3;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// Round-robin winner search starting at a rotating pointer.
// Purely combinational; o_valid is low when no request is set.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W:0]   w_off;
  logic [IDX_W:0]   w_sum;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
    w_off   = '0;
    o_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = (IDX_W+1)'(i);
        o_valid = 1'b1;
      end
    end
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= (IDX_W+1)'(N_REQ))
      w_sum = w_sum - (IDX_W+1)'(N_REQ);
    o_idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one sequential 8x8 mul unit between N_REQ requesters.
// Round-robin grant, operand capture, clear/start pulses, result return.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [OP_W*N_REQ-1:0] a_i,
  input  logic [OP_W*N_REQ-1:0] b_i,
  output logic [N_REQ-1:0]      grant_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [RES_W-1:0]      result_o,
  output logic                  busy_o,
  output logic [OP_W-1:0]       mul_a_o,
  output logic [OP_W-1:0]       mul_b_o,
  output logic                  mul_rst_o,
  output logic                  mul_start_o,
  input  logic                  mul_busy_i,
  input  logic [RES_W-1:0]      mul_result_i
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic [RES_W-1:0]   r_result;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;

  logic [IDX_W-1:0]   w_win;
  logic               w_valid;
  logic [OP_W-1:0]    w_a;
  logic [OP_W-1:0]    w_b;
  logic [N_REQ-1:0]   w_win_oh;
  logic [N_REQ-1:0]   w_idx_oh;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_valid (w_valid)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == IDX_W'(k)) begin
        w_a = a_i[OP_W*k +: OP_W];
        w_b = b_i[OP_W*k +: OP_W];
      end
    end
  end

  assign w_win_oh = N_REQ'(1) << w_win;
  assign w_idx_oh = N_REQ'(1) << r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_idx   <= w_win;
            r_grant <= w_win_oh;
            r_a     <= w_a;
            r_b     <= w_b;
            r_state <= CLR;
          end
        end
        CLR:   r_state <= START;
        START: r_state <= WAIT;
        WAIT: begin
          if (!mul_busy_i) begin
            r_result <= mul_result_i;
            // A withdrawn requester still gets its result but no pulse.
            r_done   <= w_idx_oh & req_i;
            r_grant  <= '0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_o     = r_grant;
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign busy_o      = (r_state != IDLE);
  assign mul_a_o     = r_a;
  assign mul_b_o     = r_b;
  assign mul_rst_o   = (r_state == CLR);
  assign mul_start_o = (r_state == START);

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomised and directed bench for mul_share_arb against a
// transaction-level model; the bench also plays the mul unit.
module tb_mul_share_arb;

  localparam int N  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [8*N-1:0]  a_i;
  logic [8*N-1:0]  b_i;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    done_o;
  logic [15:0]     result_o;
  logic            busy_o;
  logic [7:0]      mul_a_o;
  logic [7:0]      mul_b_o;
  logic            mul_rst_o;
  logic            mul_start_o;
  logic            mul_busy_i;
  logic [15:0]     mul_result_i;

  mul_share_arb #(.N_REQ(N), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .grant_o      (grant_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_rst_o    (mul_rst_o),
    .mul_start_o  (mul_start_o),
    .mul_busy_i   (mul_busy_i),
    .mul_result_i (mul_result_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // transaction model: one op in flight, age counts cycles since grant
  bit          m_act, m_fin;
  int          m_own, m_age, m_ptr;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_res;
  logic [N-1:0] m_done;

  // mul unit model
  int          mm_cnt, bk;
  bit          mm_stuck, rnd;
  logic [15:0] mm_prod;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("grant", 32'(grant_o), m_act ? (32'd1 << m_own) : 32'd0);
    chk("done", 32'(done_o), 32'(m_done));
    chk("result", 32'(result_o), 32'(m_res));
    chk("busy", 32'(busy_o), 32'(m_act || m_fin));
    chk("mul_a", 32'(mul_a_o), 32'(m_a));
    chk("mul_b", 32'(mul_b_o), 32'(m_b));
    chk("mul_rst", 32'(mul_rst_o), 32'(m_act && m_age == 1));
    chk("mul_start", 32'(mul_start_o), 32'(m_act && m_age == 2));
  endtask

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_own = 0; m_age = 0; m_ptr = 0;
    m_a = 0; m_b = 0; m_res = 0; m_done = '0;
  endtask

  task automatic advance();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_fin) begin
      m_fin  = 0;
      m_done = '0;
    end else if (m_act) begin
      if (m_age >= 3 && !mul_busy_i) begin
        m_res  = 16'(m_a) * 16'(m_b);
        m_act  = 0;
        m_fin  = 1;
        m_done = req_i[m_own] ? (N'(1) << m_own) : '0;
        m_ptr  = (m_own + 1) % N;
      end else begin
        m_age++;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (req_i[c]) begin
          m_act = 1; m_age = 1; m_own = c;
          m_a = a_i[8*c +: 8];
          m_b = b_i[8*c +: 8];
          break;
        end
      end
    end
  endtask

  task automatic mul_model();
    if (rst) begin
      mm_cnt = 0; mul_busy_i = 0; mul_result_i = '0;
    end else if (mul_rst_o) begin
      mul_result_i = '0;
    end else if (mul_start_o) begin
      if (rnd) bk = $urandom_range(1, 6);
      mm_prod      = 16'(mul_a_o) * 16'(mul_b_o);
      mm_cnt       = bk;
      mul_busy_i   = 1;
      mul_result_i = ~mm_prod;
    end else if (mm_cnt > 0 && !mm_stuck) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mul_busy_i   = 0;
        mul_result_i = mm_prod;
      end
    end
  endtask

  task automatic auto_req();
    for (int k = 0; k < N; k++) begin
      if (done_o[k]) req_i[k] = 1'b0;
      else if (rnd) begin
        if (!req_i[k] && $urandom_range(0, 3) == 0) req_i[k] = 1'b1;
        else if (req_i[k] && $urandom_range(0, 63) == 0) req_i[k] = 1'b0;
      end
    end
    if (rnd) begin
      a_i = (8*N)'($urandom);
      b_i = (8*N)'($urandom);
    end
  endtask

  task automatic step();
    mul_model();
    auto_req();
    advance();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_done(input int k, input int exp, input string nm,
                           output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done_o[k] && n < 200);
    if (!done_o[k]) begin
      total++; bad++;
      $display("FAIL %s: no done pulse within %0d cycles", nm, n);
    end
    chk(nm, 32'(result_o), 32'(exp));
    step();
  endtask

  int  lat;
  int  n;
  bit  seen;

  initial begin
    rst = 1; req_i = '0; a_i = '0; b_i = '0;
    mul_busy_i = 0; mul_result_i = '0;
    bk = 4; mm_cnt = 0; mm_stuck = 0; rnd = 0;
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_result", 32'(result_o), 32'd0);
    step(); step();
    rst = 0;

    // single request: 13*7
    a_i[7:0] = 8'd13; b_i[7:0] = 8'd7; req_i[0] = 1'b1;
    wait_done(0, 91, "single_res", lat);
    chk("single_latency", 32'(lat + 1), 32'(4 + bk));
    chk("single_idle_after", 32'(busy_o), 32'd0);

    // contention from reset
    rst = 1; step(); step(); rst = 0;
    bk = 1;
    a_i = {8'd0, 8'd9, 8'd5}; b_i = {8'd0, 8'd9, 8'd6};
    req_i = 3'b011;
    wait_done(0, 30, "cont_first", lat);
    step(); step();
    req_i[0] = 1'b1;
    wait_done(1, 81, "cont_second", lat);
    wait_done(0, 30, "cont_rotated", lat);

    // operand change after grant
    bk = 9;
    a_i[15:8] = 8'd200; b_i[15:8] = 8'd2; req_i[1] = 1'b1;
    repeat (5) step();
    a_i[15:8] = 8'd0;
    wait_done(1, 400, "capture_res", lat);

    // withdrawn request with requester 1 pending
    a_i[7:0] = 8'd3; b_i[7:0] = 8'd4; a_i[15:8] = 8'd7;
    req_i = 3'b011;
    repeat (5) step();
    req_i[0] = 1'b0;
    n = 0; seen = 0;
    while (!grant_o[1] && n < 40) begin
      step();
      seen |= done_o[0];
      n++;
    end
    chk("withdrawn_nodone", 32'(seen), 32'd0);
    chk("withdrawn_res", 32'(result_o), 32'd12);
    chk("withdrawn_next", 32'(grant_o), 32'b010);
    wait_done(1, 14, "withdrawn_follow", lat);

    // reset during WAIT
    a_i[23:16] = 8'd11; b_i[23:16] = 8'd12; req_i[2] = 1'b1;
    repeat (5) step();
    rst = 1;
    #1;
    chk("midrst_grant", 32'(grant_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_mula", 32'(mul_a_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    step(); step();
    rst = 0;
    wait_done(2, 132, "after_rst", lat);

    // full-scale and zero operands
    bk = 1;
    a_i[7:0] = 8'd255; b_i[7:0] = 8'd255; req_i[0] = 1'b1;
    wait_done(0, 65025, "full_scale", lat);
    bk = 9;
    a_i[7:0] = 8'd0; b_i[7:0] = 8'd77; req_i[0] = 1'b1;
    wait_done(0, 0, "zero_op", lat);

    // mul busy stuck high
    mm_stuck = 1; bk = 2; req_i[1] = 1'b1;
    repeat (40) step();
    chk("stuck_busy", 32'(busy_o), 32'd1);
    chk("stuck_grant", 32'(grant_o), 32'b010);
    rst = 1; step(); step();
    mm_stuck = 0; req_i = '0; rst = 0;
    step();

    // randomised traffic
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    n = 0;
    while ((req_i != '0 || busy_o) && n < 500) begin
      step();
      n++;
    end
    if (req_i != '0 || busy_o) begin
      total++; bad++;
      $display("FAIL drain: requests still pending after %0d cycles", n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
